led_bar_arbiter: RTL and testbench
==================================

LED_BAR_ARBITER -- requirements
Module: led_bar_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 4: minimum ownership time in ticks, range 1..255.
REQ-002 SHALL have parameter TICK_BITS, default 16: tick prescaler width, one tick every 2^TICK_BITS clk cycles.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester display request: bit0 scanner, bit1 status, bit2 alert.
REQ-006 pat0, pat1, pat2  input  8 each  LED pattern offered by requester 0/1/2.
REQ-007 grant  output  3  one-hot current owner; all zero when no owner.
REQ-008 led_out  output  8  registered bargraph drive.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 Prescaler SHALL be a free-running TICK_BITS counter; tick is a one-cycle pulse when the count is all-ones, then the count wraps to 0.
REQ-011 FSM states SHALL be IDLE, OWN and GAP.
REQ-012 Winner selection: req[2] beats all; else between req[0] and req[1], round-robin via a last-served bit; a single requester wins alone.
REQ-013 IDLE: grant=0, led_out=0; any req bit high -> OWN next cycle, grant=winner, hold counter loaded with HOLD_TICKS.
REQ-014 OWN: hold counter SHALL decrement on each tick and saturate at 0.
REQ-015 OWN release condition: hold counter==0 AND (owner's req low OR any other req high).
REQ-016 Owner still requesting, no other req, hold==0: SHALL stay in OWN with grant unchanged, no reload.
REQ-017 Preemption: req[2] high while owner is 0 or 1 SHALL switch grant to requester 2 on the next cycle regardless of the hold counter, reload HOLD_TICKS, and skip GAP.
REQ-018 Owner dropping req before hold expiry SHALL NOT release; led_out keeps tracking that owner's pattern.
REQ-019 On release, the last-served bit SHALL be updated only when the released owner was 0 or 1.
REQ-020 led_out SHALL equal the pattern of the owner one cycle after grant is set, tracking pattern changes with one-cycle latency; 0 whenever grant==0.
REQ-021 After release, with no req high at arbitration, the FSM SHALL return to IDLE.
REQ-022 grant SHALL never have more than one bit set; registered outputs only.

Reset
REQ-023 Reset assertion SHALL immediately force state=IDLE, grant=0, led_out=0, busy=0, hold counter=0, prescaler=0, last-served=1 (requester 0 wins the first tie).
REQ-024 Reset asserted mid-ownership SHALL abandon the owner; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-025 Macro LED_ARB_GAP_EN: when defined, a non-preempting release SHALL enter GAP (grant=0, led_out=0, busy=1) until the next tick, then arbitrate among current req (OWN or IDLE).
REQ-026 Without LED_ARB_GAP_EN, release SHALL arbitrate in the same cycle and move directly to OWN with the new winner, or to IDLE when none; GAP state unreachable.

Verification (HOLD_TICKS=4, TICK_BITS=2, tick every 4 cycles)
REQ-027 req=001, pat0=0x18 from IDLE -> grant=001 next cycle; led_out=0x18 one cycle later; busy=1.
REQ-028 req=011 held constantly -> grant alternates 001/010, each owner held 4 ticks (16 cycles); requester 0 first after reset.
REQ-029 Owner 0 in OWN, hold=3, req[2] rises, pat2=0xFF -> grant=100 next cycle, led_out=0xFF the cycle after, no blank cycle.
REQ-030 With LED_ARB_GAP_EN, owner 1 drops req after expiry, req[0] high -> grant=0 and led_out=0 until the next tick, then grant=001.
REQ-031 rst_n pulsed low while grant=010 -> grant=0, led_out=0, busy=0 asynchronously; after release with req=011, grant=001.

Source files
------------

// File: rtl/led_bar_arbiter_if.sv
// Request/pattern/grant bundle between the LED requesters and led_bar_arbiter.
// master = requester side, slave = arbiter side.
interface led_bar_arbiter_if;
  logic [2:0] req;
  logic [7:0] pat0;
  logic [7:0] pat1;
  logic [7:0] pat2;
  logic [2:0] grant;
  logic [7:0] led_out;
  logic       busy;

  modport master (
    output req, pat0, pat1, pat2,
    input  grant, led_out, busy
  );

  modport slave (
    input  req, pat0, pat1, pat2,
    output grant, led_out, busy
  );
endinterface

// File: rtl/led_bar_arbiter.sv
// Three-way LED bargraph arbiter: alert preempts, scanner/status share round-robin with a tick-based minimum hold.
// Optional macro LED_ARB_GAP_EN: blank the bar until the next tick after each non-preempting release.
module led_bar_arbiter #(
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned TICK_BITS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  led_bar_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

  logic [TICK_BITS-1:0] r_presc;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [2:0]           r_grant;
  logic [2:0]           w_grant_nxt;
  logic [7:0]           r_hold;
  logic [7:0]           w_hold_nxt;
  logic [7:0]           r_led;
  logic [7:0]           w_led_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic                 r_busy;
  logic                 w_tick;
  logic                 w_own_req;
  logic                 w_other_req;
  logic                 w_preempt;
  logic                 w_release;
  logic                 w_rel_last;
  logic [2:0]           w_win;
  logic [7:0]           w_owner_pat;

  // r_last: 0 = scanner served last, 1 = status served last (scanner wins the next tie)
  function automatic logic [2:0] f_pick(input logic [2:0] req, input logic last);
    if (req[2])
      return 3'b100;
    if (req[0] && req[1])
      return last ? 3'b001 : 3'b010;
    if (req[0])
      return 3'b001;
    if (req[1])
      return 3'b010;
    return 3'b000;
  endfunction

  assign w_tick      = &r_presc;
  assign w_own_req   = |(r_grant & bus.req);
  assign w_other_req = |(~r_grant & bus.req);
  assign w_preempt   = bus.req[2] && !r_grant[2];
  assign w_release   = (r_hold == 8'd0) && (!w_own_req || w_other_req);
  assign w_rel_last  = r_grant[0] ? 1'b0 : (r_grant[1] ? 1'b1 : r_last);

  always_comb begin
    w_owner_pat = 8'h00;
    if (r_grant[0])
      w_owner_pat = bus.pat0;
    else if (r_grant[1])
      w_owner_pat = bus.pat1;
    else if (r_grant[2])
      w_owner_pat = bus.pat2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_win       = 3'b000;
    case (r_state)
      S_IDLE: begin
        w_win = f_pick(bus.req, r_last);
        if (|w_win) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = w_win;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      S_OWN: begin
        if (w_preempt) begin
          w_grant_nxt = 3'b100;
          w_hold_nxt  = HOLD_LOAD;
        end else if (w_release) begin
          w_last_nxt = w_rel_last;
`ifdef LED_ARB_GAP_EN
          w_state_nxt = S_GAP;
          w_grant_nxt = 3'b000;
          w_hold_nxt  = 8'd0;
`else
          // hand over in the same cycle, tie broken by the owner just released
          w_win = f_pick(bus.req, w_rel_last);
          if (|w_win) begin
            w_grant_nxt = w_win;
            w_hold_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 3'b000;
          end
`endif
        end else if (w_tick && (r_hold != 8'd0)) begin
          w_hold_nxt = r_hold - 8'd1;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_win = f_pick(bus.req, r_last);
          if (|w_win) begin
            w_state_nxt = S_OWN;
            w_grant_nxt = w_win;
            w_hold_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 3'b000;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  // bar blanks together with grant, otherwise shows the current owner's pattern one cycle late
  assign w_led_nxt = (w_grant_nxt == 3'b000) ? 8'h00 : w_owner_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_state <= S_IDLE;
      r_grant <= 3'b000;
      r_hold  <= 8'd0;
      r_led   <= 8'h00;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_presc <= r_presc + TICK_BITS'(1);
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_hold  <= w_hold_nxt;
      r_led   <= w_led_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.grant   = r_grant;
  assign bus.led_out = r_led;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Self-checking bench for led_bar_arbiter (HOLD_TICKS=4, TICK_BITS=2) against an owner-index reference model.
// Honours LED_ARB_GAP_EN the same way the design does.
module tb_led_bar_arbiter;
  localparam int HOLD   = 4;
  localparam int TBITS  = 2;
  localparam int PERIOD = 1 << TBITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_bar_arbiter_if bus ();

  led_bar_arbiter #(.HOLD_TICKS(HOLD), .TICK_BITS(TBITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: owner as an index (-1 = nobody), hold in ticks
  int m_owner;
  bit m_gap;
  int m_hold;
  int m_last;
  int m_presc;
  int m_led;

  function automatic int pick(input logic [2:0] r, input int last);
    if (r[2]) return 2;
    if (r[0] && r[1]) return (last == 0) ? 1 : 0;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  function automatic int pat_of(input int idx);
    case (idx)
      0: return int'(bus.pat0);
      1: return int'(bus.pat1);
      2: return int'(bus.pat2);
      default: return 0;
    endcase
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [2:0] g;
    g = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    return {g, 8'(m_led), (m_owner >= 0) || m_gap};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_hold  = 0;
    m_last  = 1;
    m_presc = 0;
    m_led   = 0;
  endtask

  task automatic model_step();
    logic [2:0] r;
    bit tick;
    bit others;
    int n_owner;
    bit n_gap;
    int n_hold;
    int n_last;
    r = bus.req;
    tick = (m_presc == PERIOD - 1);
    n_owner = m_owner; n_gap = m_gap; n_hold = m_hold; n_last = m_last;
    others = 1'b0;
    for (int i = 0; i < 3; i++)
      if (i != m_owner && r[i]) others = 1'b1;
    if (m_gap) begin
      if (tick) begin
        n_gap = 1'b0;
        n_owner = pick(r, m_last);
        n_hold = HOLD;
      end
    end else if (m_owner < 0) begin
      n_owner = pick(r, m_last);
      n_hold = HOLD;
    end else if (r[2] && m_owner != 2) begin
      n_owner = 2;
      n_hold = HOLD;
    end else if (m_hold == 0 && (!r[m_owner] || others)) begin
      if (m_owner != 2) n_last = m_owner;
`ifdef LED_ARB_GAP_EN
      n_owner = -1;
      n_gap = 1'b1;
`else
      n_owner = pick(r, n_last);
      n_hold = HOLD;
`endif
    end else if (tick && m_hold > 0) begin
      n_hold = m_hold - 1;
    end
    m_led   = (n_owner < 0 || m_owner < 0) ? 0 : pat_of(m_owner);
    m_owner = n_owner;
    m_gap   = n_gap;
    m_hold  = n_hold;
    m_last  = n_last;
    m_presc = (m_presc + 1) % PERIOD;
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 3'b000; bus.pat0 = 8'h00; bus.pat1 = 8'h00; bus.pat2 = 8'h00;
    do_reset();
    checks++;
    if ({bus.grant, bus.led_out, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h need 000", {bus.grant, bus.led_out, bus.busy});
    end
    for (int i = 0; i < 3; i++) begin
      step_clk();
      checks++;
      if ({bus.grant, bus.led_out, bus.busy} !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle: got %h need %h", {bus.grant, bus.led_out, bus.busy}, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 3'b001; bus.pat0 = 8'h18;
    step_clk();
    checks++;
    if ({bus.grant, bus.busy} !== 4'b0011) begin
      errors++;
      $display("FAIL single_grant: got grant=%b busy=%b need 001 1", bus.grant, bus.busy);
    end
    step_clk();
    checks++;
    if (bus.led_out !== 8'h18) begin
      errors++;
      $display("FAIL single_led: got %h need 18", bus.led_out);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] prev;
    int last_chg;
    int nchg;
    do_reset();
    bus.req = 3'b011; bus.pat0 = 8'h0F; bus.pat1 = 8'hF0;
    prev = 3'b000; last_chg = 0; nchg = 0;
    for (int c = 1; c <= 80; c++) begin
      step_clk();
      checks++;
      if ({bus.grant, bus.led_out, bus.busy} !== exp_vec()) begin
        errors++;
        $display("FAIL rr_model c=%0d: got %h need %h", c, {bus.grant, bus.led_out, bus.busy}, exp_vec());
      end
      if (bus.grant !== prev) begin
        nchg++;
        checks++;
        if (nchg == 1 && bus.grant !== 3'b001) begin
          errors++;
          $display("FAIL rr_first: got %b need 001", bus.grant);
        end else if (nchg > 1 && ((c - last_chg) != 4 * HOLD || bus.grant !== (prev ^ 3'b011))) begin
          errors++;
          $display("FAIL rr_switch: got %0d cycles grant=%b need %0d cycles grant=%b",
                   c - last_chg, bus.grant, 4 * HOLD, prev ^ 3'b011);
        end
        prev = bus.grant;
        last_chg = c;
      end
    end
    checks++;
    if (nchg < 4) begin
      errors++;
      $display("FAIL rr_count: got %0d switches need >=4", nchg);
    end
  endtask

  task automatic test_preempt();
    bit found;
    do_reset();
    bus.req = 3'b001; bus.pat0 = 8'h3C; bus.pat2 = 8'hFF;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step_clk();
      found = (m_owner == 0 && m_hold == 3);
    end
    checks++;
    if (!found || bus.grant !== 3'b001) begin
      errors++;
      $display("FAIL preempt_setup: got grant=%b need 001 with hold 3", bus.grant);
    end
    bus.req = 3'b101;
    step_clk();
    checks++;
    if ({bus.grant, bus.led_out} !== {3'b100, 8'h3C}) begin
      errors++;
      $display("FAIL preempt_grant: got %b/%h need 100/3c", bus.grant, bus.led_out);
    end
    step_clk();
    checks++;
    if ({bus.grant, bus.led_out} !== {3'b100, 8'hFF}) begin
      errors++;
      $display("FAIL preempt_led: got %b/%h need 100/ff", bus.grant, bus.led_out);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.req = 3'b010; bus.pat1 = 8'h5A;
    for (int c = 0; c < 3; c++) step_clk();
    bus.req = 3'b000;
    for (int c = 0; c < 4; c++) begin
      step_clk();
      checks++;
      if ({bus.grant, bus.led_out, bus.busy} !== {3'b010, 8'h5A, 1'b1}) begin
        errors++;
        $display("FAIL early_drop_hold: got %h need %h", {bus.grant, bus.led_out, bus.busy}, {3'b010, 8'h5A, 1'b1});
      end
    end
    bus.pat1 = 8'hA5;
    step_clk();
    checks++;
    if (bus.led_out !== 8'hA5) begin
      errors++;
      $display("FAIL early_drop_track: got %h need a5", bus.led_out);
    end
  endtask

  task automatic test_handoff();
    bit found;
    do_reset();
    bus.req = 3'b010; bus.pat0 = 8'h81; bus.pat1 = 8'h42;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step_clk();
      found = (m_owner == 1 && m_hold == 0);
    end
    bus.req = 3'b001;
    step_clk();
`ifdef LED_ARB_GAP_EN
    checks++;
    if (!found || {bus.grant, bus.led_out, bus.busy} !== {3'b000, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL gap_enter: got %h need 001", {bus.grant, bus.led_out, bus.busy});
    end
    found = 1'b0;
    for (int c = 0; c <= PERIOD && !found; c++) begin
      step_clk();
      checks++;
      if ({bus.grant, bus.led_out, bus.busy} !== exp_vec()) begin
        errors++;
        $display("FAIL gap_model: got %h need %h", {bus.grant, bus.led_out, bus.busy}, exp_vec());
      end
      found = (bus.grant === 3'b001);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL gap_exit: got grant=%b need 001 within %0d cycles", bus.grant, PERIOD + 1);
    end
`else
    checks++;
    if (!found || bus.grant !== 3'b001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL handoff_direct: got grant=%b busy=%b need 001 1", bus.grant, bus.busy);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 3'b010; bus.pat1 = 8'h77;
    for (int c = 0; c < 3; c++) step_clk();
    checks++;
    if (bus.grant !== 3'b010) begin
      errors++;
      $display("FAIL arst_setup: got %b need 010", bus.grant);
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.grant, bus.led_out, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL arst_clear: got %h need 000", {bus.grant, bus.led_out, bus.busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 3'b011;
    step_clk();
    checks++;
    if ({bus.grant, bus.busy} !== 4'b0011) begin
      errors++;
      $display("FAIL arst_restart: got grant=%b busy=%b need 001 1", bus.grant, bus.busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.pat0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.pat1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.pat2 = 8'($urandom);
      step_clk();
      checks++;
      if ({bus.grant, bus.led_out, bus.busy} !== exp_vec() || $countones(bus.grant) > 1) begin
        errors++;
        $display("FAIL random c=%0d req=%b: got %h need %h", c, bus.req, {bus.grant, bus.led_out, bus.busy}, exp_vec());
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_early_drop();
    test_handoff();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
